// File: rtl/uart_alu_if_pkg.sv
// rtl/uart_alu_if_pkg.sv - opcodes, sequencer states and opcode check for uart_alu_if
package alu_if_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD = 6'h20;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h22;
  localparam logic [OPC_W-1:0] OP_AND = 6'h24;
  localparam logic [OPC_W-1:0] OP_OR  = 6'h25;
  localparam logic [OPC_W-1:0] OP_XOR = 6'h26;
  localparam logic [OPC_W-1:0] OP_NOR = 6'h27;
  localparam logic [OPC_W-1:0] OP_SRA = 6'h03;
  localparam logic [OPC_W-1:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  function automatic logic is_valid_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default: is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_if_if.sv
// rtl/uart_alu_if_if.sv - FIFO and ALU side signals of the uart_alu_if sequencer
interface uart_alu_if_if #(
  parameter int DBIT = 8,
  parameter int OP_W = 6
);
  logic            i_rx_empty;
  logic [DBIT-1:0] i_r_data;
  logic            o_rd_uart;
  logic            i_tx_full;
  logic            o_wr_uart;
  logic [DBIT-1:0] o_w_data;
  logic [DBIT-1:0] o_alu_a;
  logic [DBIT-1:0] o_alu_b;
  logic [OP_W-1:0] o_alu_op;
  logic [DBIT-1:0] i_alu_result;
  logic            o_busy;
  logic            o_op_err;
  logic            o_timeout;

  modport master (
    input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    output o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_op_err, o_timeout
  );

  modport slave (
    output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    input  o_rd_uart, o_wr_uart, o_w_data, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_op_err, o_timeout
  );
endinterface

// File: rtl/uart_alu_if_frame_timer.sv
// rtl/uart_alu_if_frame_timer.sv - idle watchdog: counts enabled cycles, pulses expire after TIMEOUT
module frame_timer #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // clr has priority so a byte arriving on the expiry cycle is never lost
  assign expire = en && !clr && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/uart_alu_if.sv
// rtl/uart_alu_if.sv - pops A, B, opcode from the RX FIFO, runs the ALU, pushes the result to TX
module uart_alu_if
  import alu_if_pkg::*;
#(
  parameter int              DBIT     = 8,
  parameter int              OP_W     = 6,
  parameter int              TIMEOUT  = 1000000,
  parameter int              TO_W     = 20,
  parameter logic [DBIT-1:0] ERR_BYTE = 8'hEE
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_alu_if_if.master bus
);
  state_t          state, state_n;
  logic [DBIT-1:0] result_reg, result_n;
  logic [DBIT-1:0] a_n, b_n, w_data_n;
  logic [OP_W-1:0] op_n;
  logic            wr_n, op_err_n;
  logic            pop, timer_en, expire;
  logic            in_wait;

  // the FIFO head only advances after the strobe cycle, so skip the cycle where o_rd_uart is high
  assign in_wait  = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
  assign pop      = in_wait && !bus.i_rx_empty && !bus.o_rd_uart;
  assign timer_en = ((state == WAIT_B) || (state == WAIT_OP)) && bus.i_rx_empty;

  frame_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk    (i_clk),
    .rst    (i_reset),
    .clr    (pop),
    .en     (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    a_n      = bus.o_alu_a;
    b_n      = bus.o_alu_b;
    op_n     = bus.o_alu_op;
    result_n = result_reg;
    w_data_n = bus.o_w_data;
    wr_n     = 1'b0;
    op_err_n = 1'b0;
    case (state)
      WAIT_A: if (pop) begin
        a_n     = bus.i_r_data;
        state_n = WAIT_B;
      end
      WAIT_B: if (pop) begin
        b_n     = bus.i_r_data;
        state_n = WAIT_OP;
      end else if (expire) begin
        state_n = WAIT_A;
      end
      WAIT_OP: if (pop) begin
        op_n    = bus.i_r_data[OP_W-1:0];
        state_n = EXEC;
      end else if (expire) begin
        state_n = WAIT_A;
      end
      EXEC: begin
        if (is_valid_op(OPC_W'(bus.o_alu_op))) begin
          result_n = bus.i_alu_result;
        end else begin
          result_n = ERR_BYTE;
          op_err_n = 1'b1;
        end
        state_n = SEND;
      end
      SEND: if (!bus.i_tx_full) begin
        w_data_n = result_reg;
        wr_n     = 1'b1;
        state_n  = WAIT_A;
      end
      default: state_n = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= WAIT_A;
      result_reg    <= '0;
      bus.o_rd_uart <= 1'b0;
      bus.o_wr_uart <= 1'b0;
      bus.o_w_data  <= '0;
      bus.o_alu_a   <= '0;
      bus.o_alu_b   <= '0;
      bus.o_alu_op  <= '0;
      bus.o_busy    <= 1'b0;
      bus.o_op_err  <= 1'b0;
      bus.o_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      result_reg    <= result_n;
      bus.o_rd_uart <= pop;
      bus.o_wr_uart <= wr_n;
      bus.o_w_data  <= w_data_n;
      bus.o_alu_a   <= a_n;
      bus.o_alu_b   <= b_n;
      bus.o_alu_op  <= op_n;
      bus.o_busy    <= (state_n != WAIT_A);
      bus.o_op_err  <= op_err_n;
      bus.o_timeout <= expire;
    end
  end
endmodule

// File: tb/tb_uart_alu_if.sv
// tb/tb_uart_alu_if.sv - bench for uart_alu_if with FIFO and ALU models
module tb_uart_alu_if;
  localparam int DBIT = 8;
  localparam int OP_W = 6;
  localparam int TMO  = 100;
  localparam int TO_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_full = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  logic [7:0] pushes[$];
  int cyc = 0, pops = 0, consec = 0, op_errs = 0, timeouts = 0;
  int last_pop_cyc = 0, push_cyc = 0;
  logic prev_rd = 1'b0;

  uart_alu_if_if #(.DBIT(DBIT), .OP_W(OP_W)) bus ();

  uart_alu_if #(
    .DBIT(DBIT), .OP_W(OP_W), .TIMEOUT(TMO), .TO_W(TO_W), .ERR_BYTE(8'hEE)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return $signed(a) >>> b;
      6'h02: return a >> b;
      default: return 8'h5A ^ a;
    endcase
  endfunction

  function automatic logic [7:0] expected_push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob);
    logic [5:0] op;
    op = ob[5:0];
    if (op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02}) return alu(a, b, op);
    return 8'hEE;
  endfunction

  assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  assign bus.i_tx_full    = tx_full;

  // FIFO models and event counters, all updated away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (bus.o_rd_uart) begin
      pops++;
      last_pop_cyc = cyc;
      if (prev_rd) consec++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    prev_rd = bus.o_rd_uart;
    if (bus.o_wr_uart) begin
      pushes.push_back(bus.o_w_data);
      push_cyc = cyc;
    end
    if (bus.o_op_err) op_errs++;
    if (bus.o_timeout) timeouts++;
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  end

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob);
    logic [7:0] exp;
    exp = expected_push(a, b, ob);
    pushes.delete();
    rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(ob);
    for (int i = 0; i < 40 && pushes.size() == 0; i++) @(negedge clk);
    checks++;
    if (pushes.size() != 1) begin
      errors++; $display("FAIL frame_push_count got=%0d want=1", pushes.size());
    end else begin
      checks++;
      if (pushes[0] !== exp) begin
        errors++; $display("FAIL frame_data got=%h want=%h", pushes[0], exp);
      end
      checks++;
      if (push_cyc - last_pop_cyc != 2) begin
        errors++; $display("FAIL frame_latency got=%0d want=2", push_cyc - last_pop_cyc);
      end
    end
    checks++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !== {a, b, ob[5:0]}) begin
      errors++; $display("FAIL frame_operands got=%h/%h/%h want=%h/%h/%h",
                         bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, a, b, ob[5:0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pushes.size() != 1 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL frame_settle pushes=%0d busy=%b want 1/0", pushes.size(), bus.o_busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.o_rd_uart, bus.o_wr_uart, bus.o_w_data, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op,
         bus.o_busy, bus.o_op_err, bus.o_timeout} !== '0) begin
      errors++; $display("FAIL %s rd=%b wr=%b w=%h a=%h b=%h op=%h busy=%b err=%b to=%b want all 0", name,
                         bus.o_rd_uart, bus.o_wr_uart, bus.o_w_data, bus.o_alu_a, bus.o_alu_b,
                         bus.o_alu_op, bus.o_busy, bus.o_op_err, bus.o_timeout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_basic();
    run_frame(8'h05, 8'h03, 8'h20);
    run_frame(8'h03, 8'h05, 8'h22);
    run_frame(8'hF0, 8'h0F, 8'h27);
  endtask

  task automatic test_op_err();
    int e0;
    e0 = op_errs;
    run_frame(8'h01, 8'h02, 8'h3F);
    checks++;
    if (op_errs - e0 != 1) begin
      errors++; $display("FAIL op_err_pulses got=%0d want=1", op_errs - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    logic [7:0] a, b, ob;
    int c0;
    c0 = consec;
    pushes.delete();
    rx_q.push_back(8'h05); rx_q.push_back(8'h03); rx_q.push_back(8'h20);
    rx_q.push_back(8'hF0); rx_q.push_back(8'h0F); rx_q.push_back(8'h27);
    for (int i = 0; i < 80 && pushes.size() < 2; i++) @(negedge clk);
    checks++;
    if (pushes.size() != 2) begin
      errors++; $display("FAIL b2b_count got=%0d want=2", pushes.size());
    end else begin
      checks++;
      if (pushes[0] !== 8'h08 || pushes[1] !== 8'h00) begin
        errors++; $display("FAIL b2b_data got=%h,%h want=08,00", pushes[0], pushes[1]);
      end
    end
    repeat (3) @(negedge clk);
    pushes.delete();
    for (int f = 0; f < 10; f++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ob = 8'($urandom_range(0, 255));
      else ob = {2'($urandom_range(0, 3)), valid_ops[$urandom_range(0, 7)]};
      rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(ob);
      exp_q.push_back(expected_push(a, b, ob));
    end
    for (int i = 0; i < 500 && pushes.size() < 10; i++) @(negedge clk);
    checks++;
    if (pushes.size() != 10) begin
      errors++; $display("FAIL rand_count got=%0d want=10", pushes.size());
    end else begin
      for (int f = 0; f < 10; f++) begin
        checks++;
        if (pushes[f] !== exp_q[f]) begin
          errors++; $display("FAIL rand_frame%0d got=%h want=%h", f, pushes[f], exp_q[f]);
        end
      end
    end
    checks++;
    if (consec != c0) begin
      errors++; $display("FAIL consecutive_pops got=%0d want=0", consec - c0);
    end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = timeouts;
    pushes.delete();
    rx_q.push_back(8'h11);
    repeat (TMO - 10) @(negedge clk);
    checks++;
    if (timeouts != t0 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early pulses=%0d busy=%b want 0/1", timeouts - t0, bus.o_busy);
    end
    for (int i = 0; i < 40 && timeouts == t0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (timeouts - t0 != 1) begin
      errors++; $display("FAIL timeout_pulses got=%0d want=1", timeouts - t0);
    end
    checks++;
    if (bus.o_busy !== 1'b0 || pushes.size() != 0) begin
      errors++; $display("FAIL timeout_drop busy=%b pushes=%0d want 0/0", bus.o_busy, pushes.size());
    end
    run_frame(8'h02, 8'h02, 8'h20);
  endtask

  task automatic test_tx_full();
    int p0, t0;
    p0 = pops;
    t0 = timeouts;
    tx_full = 1'b1;
    pushes.delete();
    rx_q.push_back(8'h09); rx_q.push_back(8'h04); rx_q.push_back(8'h26);
    rx_q.push_back(8'h07); rx_q.push_back(8'h01); rx_q.push_back(8'h20);
    for (int i = 0; i < 30 && pops - p0 < 3; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    checks++;
    if (pushes.size() != 0 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL txfull_hold pushes=%0d busy=%b want 0/1", pushes.size(), bus.o_busy);
    end
    checks++;
    if (pops - p0 != 3 || timeouts != t0) begin
      errors++; $display("FAIL txfull_quiet pops=%0d timeouts=%0d want 3/0", pops - p0, timeouts - t0);
    end
    tx_full = 1'b0;
    for (int i = 0; i < 10 && pushes.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (pushes.size() != 1 || pushes[0] !== 8'h0D) begin
      errors++; $display("FAIL txfull_release count=%0d data=%h want 1/0d", pushes.size(),
                         (pushes.size() > 0) ? pushes[0] : 8'hXX);
    end
    for (int i = 0; i < 30 && pushes.size() < 2; i++) @(negedge clk);
    checks++;
    if (pushes.size() != 2 || pushes[1] !== 8'h08) begin
      errors++; $display("FAIL txfull_next count=%0d want 2 with second=08", pushes.size());
    end
  endtask

  task automatic test_async_reset();
    int p0;
    p0 = pops;
    rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    for (int i = 0; i < 20 && pops - p0 < 2; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_alu_a !== 8'h33 || bus.o_alu_b !== 8'h44 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset a=%h b=%h busy=%b want 33/44/1", bus.o_alu_a, bus.o_alu_b, bus.o_busy);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'h0A, 8'h14, 8'h25);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_rx_empty = 1'b1;
    bus.i_r_data   = 8'h00;
    test_reset();
    test_basic();
    test_op_err();
    test_back_to_back();
    test_timeout();
    test_tx_full();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
